// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Shares one WxW array multiplier between NREQ requesters. A round-robin
// arbiter picks one request while idle. It latches that requester's operands
// onto the multiplier inputs and waits MULT_LAT cycles for the product to
// settle. It then captures the product and reports it with a one-cycle done
// pulse tagged with the requester index. All outputs are registered.
//
// Optional feature (compile-time macro MULT_SHARE_ZERO_BYPASS_EN):
//   When defined, a winner with a zero operand completes in the same idle edge.
//   The product 0 is returned directly, and the multiplier is left untouched.
//
// Parameters:
//   W        operand width; product is 2*W bits
//   NREQ     number of requesters (2..8)
//   MULT_LAT multiplier settle time in cycles (1..255)
//   IDW      requester id width, equal to clog2(NREQ)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req      per-requester request level
//   a_in     packed operand A, requester i at [i*W +: W]
//   b_in     packed operand B, same packing
//   gnt      one-hot single-cycle pulse: operands of that requester accepted
//   mult_a   multiplier input a (holds while idle)
//   mult_b   multiplier input b (holds while idle)
//   mult_p   multiplier output p
//   done     single-cycle pulse: product valid on p
//   done_id  requester index of the completed product
//   p        captured product, holds until the next done
//   busy     high while waiting on the multiplier
module mult_share_arbiter #(
    parameter int unsigned W        = 4,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MULT_LAT = 1,
    parameter int unsigned IDW      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      mult_a,
    output logic [W-1:0]      mult_b,
    input  logic [2*W-1:0]    mult_p,
    output logic              done,
    output logic [IDW-1:0]    done_id,
    output logic [2*W-1:0]    p,
    output logic              busy
);

    localparam int unsigned CntW    = 8;
    localparam logic [CntW-1:0] CntInit = CntW'(MULT_LAT);
    // Pointer starts at the last requester so requester 0 is searched first.
    localparam logic [IDW-1:0]  PtrInit = IDW'(NREQ - 1);

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    mult_a_q, mult_a_d;
    logic [W-1:0]    mult_b_q, mult_b_d;
    logic            done_q, done_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic [2*W-1:0]  p_q, p_d;
    logic            busy_q, busy_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    // ------------------------------------------------------------------
    // Round-robin search: first set request at ptr+1, ptr+2, ... (mod NREQ)
    // ------------------------------------------------------------------
    logic            win_valid;
    logic [IDW-1:0]  win_id;
    logic [NREQ-1:0] win_oh;
    int unsigned     idx;

    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_oh    = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!win_valid && (i == idx) && req[i]) begin
                    win_valid = 1'b1;
                    win_id    = IDW'(i);
                    win_oh[i] = 1'b1;
                end
            end
        end
    end

    // Winner operand mux, driven by the one-hot winner vector.
    logic [W-1:0] win_a, win_b;

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_a = a_in[i*W +: W];
                win_b = b_in[i*W +: W];
            end
        end
    end

    // A zero operand can skip the multiplier entirely when the bypass is built in.
    logic bypass;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
    assign bypass = (win_a == '0) || (win_b == '0);
`else
    assign bypass = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        p_d       = p_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    gnt_d = win_oh;
                    ptr_d = win_id;
                    if (bypass) begin
                        done_d    = 1'b1;
                        done_id_d = win_id;
                        p_d       = '0;
                    end else begin
                        mult_a_d = win_a;
                        mult_b_d = win_b;
                        cnt_d    = CntInit;
                        id_d     = win_id;
                        busy_d   = 1'b1;
                        state_d  = StWait;
                    end
                end
            end

            StWait: begin
                // New requests are not sampled here; requesters hold req until gnt.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    p_d       = mult_p;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            p_q       <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= PtrInit;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            p_q       <= p_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign mult_a  = mult_a_q;
    assign mult_b  = mult_b_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign p       = p_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter. Three instances differ only in MULT_LAT
// (1, 3 and 4). Each instance drives its own behavioural multiplier.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_share_arbiter;

    localparam int unsigned W    = 4;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;

    int checks = 0;
    int errors = 0;

    // Instance with MULT_LAT = 1
    logic           rst_1;
    logic [3:0]     req_1, gnt_1;
    logic [W-1:0]   mult_a_1, mult_b_1;
    logic [2*W-1:0] mult_p_1, p_1;
    logic           done_1, busy_1;
    logic [IDW-1:0] done_id_1;

    // Instance with MULT_LAT = 3
    logic           rst_3;
    logic [3:0]     req_3, gnt_3;
    logic [W-1:0]   mult_a_3, mult_b_3;
    logic [2*W-1:0] mult_p_3, p_3;
    logic           done_3, busy_3;
    logic [IDW-1:0] done_id_3;

    // Instance with MULT_LAT = 4
    logic           rst_4;
    logic [3:0]     req_4, gnt_4;
    logic [W-1:0]   mult_a_4, mult_b_4;
    logic [2*W-1:0] mult_p_4, p_4;
    logic           done_4, busy_4;
    logic [IDW-1:0] done_id_4;

    assign mult_p_1 = 8'(mult_a_1) * 8'(mult_b_1);
    assign mult_p_3 = 8'(mult_a_3) * 8'(mult_b_3);
    assign mult_p_4 = 8'(mult_a_4) * 8'(mult_b_4);

    mult_share_arbiter #(.W(W), .NREQ(NREQ), .MULT_LAT(1), .IDW(IDW)) u_dut1 (
        .clk(clk), .rst(rst_1), .req(req_1), .a_in(a_in), .b_in(b_in), .gnt(gnt_1),
        .mult_a(mult_a_1), .mult_b(mult_b_1), .mult_p(mult_p_1), .done(done_1),
        .done_id(done_id_1), .p(p_1), .busy(busy_1)
    );

    mult_share_arbiter #(.W(W), .NREQ(NREQ), .MULT_LAT(3), .IDW(IDW)) u_dut3 (
        .clk(clk), .rst(rst_3), .req(req_3), .a_in(a_in), .b_in(b_in), .gnt(gnt_3),
        .mult_a(mult_a_3), .mult_b(mult_b_3), .mult_p(mult_p_3), .done(done_3),
        .done_id(done_id_3), .p(p_3), .busy(busy_3)
    );

    mult_share_arbiter #(.W(W), .NREQ(NREQ), .MULT_LAT(4), .IDW(IDW)) u_dut4 (
        .clk(clk), .rst(rst_4), .req(req_4), .a_in(a_in), .b_in(b_in), .gnt(gnt_4),
        .mult_a(mult_a_4), .mult_b(mult_b_4), .mult_p(mult_p_4), .done(done_4),
        .done_id(done_id_4), .p(p_4), .busy(busy_4)
    );

    task automatic reset_1();
        rst_1 = 1'b1;
        req_1 = '0;
        @(negedge clk);
        rst_1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_1 = 1'b1; rst_3 = 1'b1; rst_4 = 1'b1;
        req_1 = '0;   req_3 = '0;   req_4 = '0;
        a_in  = '0;   b_in  = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({gnt_1, done_1, busy_1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected %b", {gnt_1, done_1, busy_1}, 6'b0);
        end
        checks++;
        if ({mult_a_1, mult_b_1} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mult got %h expected %h", {mult_a_1, mult_b_1}, 8'h00);
        end
        checks++;
        if ({p_1, done_id_1} !== 10'h000) begin
            errors++;
            $display("FAIL reset_result got %h expected %h", {p_1, done_id_1}, 10'h000);
        end
        rst_1 = 1'b0; rst_3 = 1'b0; rst_4 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt_1, done_1, busy_1, p_1} !== 14'b0) begin
            errors++;
            $display("FAIL idle_no_req got %h expected %h", {gnt_1, done_1, busy_1, p_1}, 14'h0);
        end
    endtask

    task automatic test_single();
        reset_1();
        a_in = '0; b_in = '0;
        a_in[3:0] = 4'd11;
        b_in[3:0] = 4'd10;
        req_1 = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt_1 !== 4'b0001) begin
            errors++;
            $display("FAIL single_gnt got %b expected %b", gnt_1, 4'b0001);
        end
        checks++;
        if ({mult_a_1, mult_b_1} !== {4'd11, 4'd10}) begin
            errors++;
            $display("FAIL single_operands got %0d,%0d expected 11,10", mult_a_1, mult_b_1);
        end
        checks++;
        if ({busy_1, done_1} !== 2'b10) begin
            errors++;
            $display("FAIL single_busy_done got %b expected %b", {busy_1, done_1}, 2'b10);
        end
        req_1 = '0;
        @(negedge clk);
        checks++;
        if ({done_1, done_id_1, p_1} !== {1'b1, 2'd0, 8'd110}) begin
            errors++;
            $display("FAIL single_done got done=%b id=%0d p=%0d expected done=1 id=0 p=110",
                     done_1, done_id_1, p_1);
        end
        checks++;
        if ({gnt_1, busy_1} !== 5'b0) begin
            errors++;
            $display("FAIL single_after got %b expected %b", {gnt_1, busy_1}, 5'b0);
        end
        @(negedge clk);
        checks++;
        if ({done_1, p_1} !== {1'b0, 8'd110}) begin
            errors++;
            $display("FAIL single_hold got done=%b p=%0d expected done=0 p=110", done_1, p_1);
        end
    endtask

    task automatic test_all_four();
        logic [7:0] ep [4];
        logic [3:0] exp_g;
        ep[0] = 8'd225; ep[1] = 8'd140; ep[2] = 8'd72; ep[3] = 8'd33;
        reset_1();
        a_in  = {4'd3, 4'd9, 4'd10, 4'd15};
        b_in  = {4'd11, 4'd8, 4'd14, 4'd15};
        req_1 = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_g = 4'b0001 << i;
            checks++;
            if ({gnt_1, done_1} !== {exp_g, 1'b0}) begin
                errors++;
                $display("FAIL all4_gnt[%0d] got %b done=%b expected %b done=0",
                         i, gnt_1, done_1, exp_g);
            end
            req_1[i] = 1'b0;
            @(negedge clk);
            checks++;
            if ({done_1, done_id_1, p_1, gnt_1} !== {1'b1, 2'(i), ep[i], 4'b0}) begin
                errors++;
                $display("FAIL all4_done[%0d] got done=%b id=%0d p=%0d gnt=%b expected 1 %0d %0d 0",
                         i, done_1, done_id_1, p_1, gnt_1, i, ep[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({gnt_1, done_1, busy_1} !== 6'b0) begin
            errors++;
            $display("FAIL all4_drained got %b expected %b", {gnt_1, done_1, busy_1}, 6'b0);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id;
        logic [7:0] exp_p;
        logic [3:0] exp_g;
        rst_3 = 1'b1;
        req_3 = '0;
        @(negedge clk);
        rst_3 = 1'b0;
        a_in = '0; b_in = '0;
        a_in[3:0]  = 4'd2; b_in[3:0]  = 4'd3;
        a_in[11:8] = 4'd5; b_in[11:8] = 4'd4;
        req_3 = 4'b0101;
        for (int op = 0; op < 4; op++) begin
            exp_id = (op % 2 == 0) ? 2'd0 : 2'd2;
            exp_p  = (op % 2 == 0) ? 8'd6 : 8'd20;
            exp_g  = 4'b0001 << exp_id;
            @(negedge clk);
            checks++;
            if ({gnt_3, busy_3, done_3} !== {exp_g, 2'b10}) begin
                errors++;
                $display("FAIL fair_gnt[%0d] got gnt=%b busy=%b done=%b expected %b 1 0",
                         op, gnt_3, busy_3, done_3, exp_g);
            end
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                checks++;
                if ({gnt_3, busy_3, done_3} !== 6'b000010) begin
                    errors++;
                    $display("FAIL fair_wait[%0d.%0d] got gnt=%b busy=%b done=%b expected 0 1 0",
                             op, c, gnt_3, busy_3, done_3);
                end
            end
            @(negedge clk);
            checks++;
            if ({done_3, done_id_3, p_3, busy_3} !== {1'b1, exp_id, exp_p, 1'b0}) begin
                errors++;
                $display("FAIL fair_done[%0d] got done=%b id=%0d p=%0d busy=%b expected 1 %0d %0d 0",
                         op, done_3, done_id_3, p_3, busy_3, exp_id, exp_p);
            end
        end
        req_3 = '0;
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        rst_4 = 1'b1;
        req_4 = '0;
        @(negedge clk);
        rst_4 = 1'b0;
        a_in = '0; b_in = '0;
        a_in[7:4] = 4'd7; b_in[7:4] = 4'd9;
        req_4 = 4'b0010;
        @(negedge clk);
        checks++;
        if ({gnt_4, mult_a_4, mult_b_4, busy_4} !== {4'b0010, 4'd7, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL rmid_gnt got gnt=%b a=%0d b=%0d busy=%b expected 0010 7 9 1",
                     gnt_4, mult_a_4, mult_b_4, busy_4);
        end
        req_4 = '0;
        @(negedge clk);
        @(negedge clk);
        rst_4 = 1'b1;
        #1;
        checks++;
        if ({gnt_4, mult_a_4, mult_b_4, done_4, done_id_4, p_4, busy_4} !== 24'h0) begin
            errors++;
            $display("FAIL rmid_async_clear got %h expected %h",
                     {gnt_4, mult_a_4, mult_b_4, done_4, done_id_4, p_4, busy_4}, 24'h0);
        end
        @(negedge clk);
        rst_4 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_4 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rmid_no_done got %b expected %b", seen, 1'b0);
        end
        checks++;
        if ({busy_4, p_4} !== 9'h0) begin
            errors++;
            $display("FAIL rmid_idle got %h expected %h", {busy_4, p_4}, 9'h0);
        end
        a_in[15:12] = 4'd2; b_in[15:12] = 4'd2;
        req_4 = 4'b1010;
        @(negedge clk);
        checks++;
        if (gnt_4 !== 4'b0010) begin
            errors++;
            $display("FAIL rmid_regrant got %b expected %b", gnt_4, 4'b0010);
        end
        req_4 = '0;
    endtask

    task automatic test_zero_operand();
        reset_1();
        a_in = '0; b_in = '0;
        a_in[7:4] = 4'd7; b_in[7:4] = 4'd9;
        req_1 = 4'b0010;
        @(negedge clk);
        req_1 = '0;
        @(negedge clk);
        checks++;
        if ({done_1, p_1} !== {1'b1, 8'd63}) begin
            errors++;
            $display("FAIL zero_setup got done=%b p=%0d expected 1 63", done_1, p_1);
        end
        a_in[3:0] = 4'd8; b_in[3:0] = 4'd0;
        req_1 = 4'b0001;
        @(negedge clk);
`ifdef MULT_SHARE_ZERO_BYPASS_EN
        checks++;
        if ({gnt_1, done_1, done_id_1, p_1, busy_1} !== {4'b0001, 1'b1, 2'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_bypass got gnt=%b done=%b id=%0d p=%0d busy=%b expected 0001 1 0 0 0",
                     gnt_1, done_1, done_id_1, p_1, busy_1);
        end
        checks++;
        if ({mult_a_1, mult_b_1} !== {4'd7, 4'd9}) begin
            errors++;
            $display("FAIL zero_mult_hold got %0d,%0d expected 7,9", mult_a_1, mult_b_1);
        end
        req_1 = '0;
        @(negedge clk);
        checks++;
        if ({done_1, busy_1} !== 2'b00) begin
            errors++;
            $display("FAIL zero_after got %b expected %b", {done_1, busy_1}, 2'b00);
        end
`else
        checks++;
        if ({gnt_1, done_1, busy_1} !== {4'b0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL zero_gnt got gnt=%b done=%b busy=%b expected 0001 0 1",
                     gnt_1, done_1, busy_1);
        end
        checks++;
        if ({mult_a_1, mult_b_1} !== {4'd8, 4'd0}) begin
            errors++;
            $display("FAIL zero_mult got %0d,%0d expected 8,0", mult_a_1, mult_b_1);
        end
        req_1 = '0;
        @(negedge clk);
        checks++;
        if ({done_1, done_id_1, p_1, busy_1} !== {1'b1, 2'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_done got done=%b id=%0d p=%0d busy=%b expected 1 0 0 0",
                     done_1, done_id_1, p_1, busy_1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_reset_mid_wait();
        test_zero_operand();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 4x4 Braun array multiplier (ArrayMult, ports a/b/p) between NREQ requesters.
- Round-robin arbitration; latches the winner's operands onto the multiplier inputs and waits MULT_LAT cycles.
- Captures the product and returns it with the requester id as a one-cycle done pulse.
- Sits between requester blocks and the single multiplier instance.

Parameters:
- W, 4, operand width; product is 2W.
- NREQ, 4, number of requesters (2..8).
- MULT_LAT, 1, cycles allowed for the multiplier to settle after operands are driven (1..255).
- IDW, 2, id width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- a_in  in  NREQ*W  packed operand A; requester i at [i*W +: W].
- b_in  in  NREQ*W  packed operand B; same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester accepted.
- mult_a  out  W  to multiplier input a.
- mult_b  out  W  to multiplier input b.
- mult_p  in  2W  from multiplier output p.
- done  out  1  one-cycle pulse: product valid.
- done_id  out  IDW  requester index of the completed product.
- p  out  2W  captured product; holds until the next done.
- busy  out  1  high while in WAIT.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, mult_a=0, mult_b=0, done=0, done_id=0, p=0, busy=0, state=IDLE, rr pointer=NREQ-1 (so req[0] has top priority first).
- States:
  - IDLE: at a clock edge with req!=0, select the winner (see arbitration). Register gnt=onehot(winner), mult_a/mult_b=winner operands, cnt=MULT_LAT, id=winner, pointer=winner, busy=1. Go to WAIT. With req=0, stay in IDLE.
  - WAIT: gnt cleared after one cycle. Decrement cnt each edge. At the edge where cnt==1: p<=mult_p, done<=1, done_id<=id, busy<=0, go to IDLE.
- Arbitration: search req starting at index pointer+1, wrapping modulo NREQ. The first set bit wins.
- Latency: req sampled at edge E0. gnt and mult_a/b are visible after E0. done and p are visible after edge E0+MULT_LAT.
- Throughput: at most one operation per MULT_LAT+1 cycles. Requests arriving in WAIT are ignored; they are held by the requester and sampled in IDLE.
- A request is not re-granted while in WAIT. Its req still high at the next IDLE sample counts as a new request.
- done clears after one cycle. mult_a/mult_b hold their last values in IDLE.
- Arithmetic: p = mult_p exactly (2W bits, unsigned). The arbiter performs no arithmetic.
- Simultaneous requests: exactly one gnt bit is set; the others wait.
- Reset mid-operation: the in-flight operation is discarded and no done is issued. All values return to reset.
- Operands must be stable from req assertion until gnt is observed.

Optional Feature:
- Macro MULT_SHARE_ZERO_BYPASS_EN.
- Defined: in IDLE, if the winner's a or b is 0, register gnt, done=1, done_id=winner, p=0 at the same edge. State stays IDLE, busy stays 0, and mult_a/mult_b are not updated. Latency is 1 edge regardless of MULT_LAT.
- Undefined: zero operands take the normal WAIT path.

Test Plan:
- Single request: req=0001, a0=11, b0=10, MULT_LAT=1 -> gnt=0001 one cycle; done after 2 edges with p=110, done_id=0.
- All four request at once: operands (15,15), (10,14), (9,8), (3,11), each held until its gnt -> grant order 0,1,2,3; products 225, 140, 72, 33; one done every 2 cycles.
- Fairness: req0 and req2 held high continuously, MULT_LAT=3 -> grants alternate 0,2,0,2; done spacing 4 cycles; busy high 3 cycles per operation.
- Reset mid-WAIT: grant requester 1 (7x9), MULT_LAT=4, assert rst 2 cycles after gnt -> no done; all outputs 0; next grant goes to the lowest-index active request.
- Zero operand: a=8, b=0. With MULT_SHARE_ZERO_BYPASS_EN -> done 1 edge after sampling, p=0, mult_a/mult_b unchanged. Without it -> done after MULT_LAT+1 edges, p=0.
